if_id_skid_stage: RTL
=====================

# if_id_skid_stage

Parametrised, elastic IF/ID pipeline stage that replaces the fixed enable/flush register between fetch and decode. It carries PC and instruction with a valid/ready handshake. An optional 2-entry skid buffer lets the ready path to fetch be registered and still sustain one instruction per cycle. Flush inserts a NOP bubble, and an occupancy count is exported for the hazard unit.

## Interface
Parameters:
- PC_W, 32, PC width in bits.
- INSTR_W, 32, instruction width in bits.
- NOP_INSTR, 32'h0000_0013, bubble value driven on instr_o when empty or flushed.
- SKID, 1, selects the mode: 1 = 2-entry skid buffer with registered ready_o; 0 = single register with combinational ready_o.

Ports:
- clk  in  1  clock. Single clock domain; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held entries (branch/exception redirect).
- valid_i  in  1  fetch presents an instruction.
- ready_o  out  1  stage can accept this cycle.
- pc_i  in  PC_W  fetch PC.
- instr_i  in  INSTR_W  fetched instruction.
- valid_o  out  1  decode-side instruction valid.
- ready_i  in  1  decode accepts this cycle (deasserted = stall).
- pc_o  out  PC_W  PC of the head entry.
- instr_o  out  INSTR_W  instruction of the head entry.
- count_o  out  2  entries held: 0, 1 or 2.

## Operation
- Transfers: accept = valid_i & ready_o; drain = valid_o & ready_i.
- Storage: main register (head, drives outputs) and skid register (present only when SKID=1).
- States: EMPTY, FULL (main only), SKID (main + skid). count_o = 0 / 1 / 2 respectively.
- EMPTY:
  - accept → FULL, main ← input.
- FULL:
  - accept & drain → FULL, main ← input.
  - accept & ~drain → SKID, skid ← input.
  - drain & ~accept → EMPTY.
  - neither → hold.
- SKID:
  - ready_o = 0, so no accept.
  - drain → FULL, main ← skid.
  - otherwise hold.
- ready_o with SKID=1: state != SKID, decoded from registered state only; no combinational path from ready_i.
- SKID=0 behaviour:
  - SKID state is unreachable.
  - ready_o = ~valid_o | ready_i.
  - accept & ~drain from FULL cannot occur.
- Flush (priority over everything except rst):
  - Next state EMPTY; both entries discarded.
  - Any accept in the flush cycle is consumed from fetch and dropped.
  - Any drain in the flush cycle completes normally; decode sees it.
- Output encoding:
  - valid_o = (state != EMPTY).
  - When EMPTY: pc_o = 0, instr_o = NOP_INSTR.
  - Payload registers are cleared to 0 / NOP_INSTR on rst, on flush and on drain to EMPTY, so outputs never show stale data.
- Payload is not modified. No width conversion: pc_i and instr_i are stored verbatim.

## Timing
- Reset (rst high at an edge): next cycle state EMPTY, valid_o=0, pc_o=0, instr_o=NOP_INSTR, count_o=0.
- ready_o during reset: forced 0 while rst is high. It is 1 in the first cycle after rst falls.
- rst mid-operation: identical to reset from idle; entries are lost with no drain.
- Latency: an instruction accepted at edge N appears on valid_o/pc_o/instr_o after edge N, i.e. in cycle N+1.
- Throughput: 1 instruction/cycle while ready_i=1, in both modes.
- Stall response: in SKID=1 mode, ready_i falling takes up one more instruction (into skid); ready_o falls in the following cycle.
- Order: strictly FIFO. The skid entry is always younger than main.
- flush and ready_i together: the head drains at that edge; state → EMPTY at the same edge.

## Structure
- Shared package pipe_pkg holds:
  - NOP_INSTR constant (default source for the parameter).
  - stage_state_e enum {EMPTY, FULL, SKID}.
  - if_id_payload_t struct {pc, instr}, reused by later stages.
- No sub-module. Storage and the FSM are one always_ff plus one always_comb. The SKID=0 path is a generate branch.

## Test plan
- Reset then idle: after rst, check valid_o=0, pc_o=0, instr_o=0x00000013, count_o=0, ready_o=1.
- Streaming, ready_i=1: drive PCs 0x00,0x04,0x08 back-to-back → same PCs on pc_o in cycles N+1..N+3, with no bubbles, in both SKID settings.
- Stall into skid (SKID=1): accept 0x10; drop ready_i as 0x14 is offered.
  - Check count_o=2 and ready_o=0 in the next cycle.
  - Raise ready_i → 0x10, then 0x14 drain in order, and ready_o returns to 1.
- Flush with count_o=2 and valid_i=1 (PC 0x20): next cycle valid_o=0, instr_o=NOP, count_o=0; PC 0x20 never appears.
- Flush coinciding with drain of PC 0x30: decode observes 0x30 in that cycle, then the stage is EMPTY.
- rst asserted with count_o=2: next cycle all outputs at reset values, ready_o=0 while rst is high.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the fetch/decode boundary and later stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  // Canonical bubble: ADDI x0, x0, 0.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Default payload widths used by the shared struct.
  localparam int unsigned PAYLOAD_PC_W    = 32;
  localparam int unsigned PAYLOAD_INSTR_W = 32;

  // Occupancy states of an elastic stage; the encoding equals the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

  // PC plus instruction as carried between front-end stages.
  typedef struct packed {
    logic [PAYLOAD_PC_W-1:0]    pc;
    logic [PAYLOAD_INSTR_W-1:0] instr;
  } if_id_payload_t;

  // Number of entries held in a given occupancy state.
  function automatic logic [1:0] state_count(input stage_state_e st);
    logic [1:0] cnt;
    case (st)
      EMPTY:   cnt = 2'd0;
      FULL:    cnt = 2'd1;
      SKID:    cnt = 2'd2;
      default: cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/if_id_skid_stage.sv
// Elastic IF/ID stage: main register drives decode, optional skid register absorbs one extra entry.
// Latency: 1 cycle from accept to valid_o; 1 instruction/cycle sustained while ready_i=1.
// Backpressure: SKID=1 gives a registered ready_o (falls one cycle after the stall); SKID=0 gives ready_o = ~valid_o | ready_i.
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned           PC_W      = 32,
  parameter int unsigned           INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]    NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR),
  parameter bit                    SKID      = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [1:0]         count_o
);

  // Enum literals are written with the package scope because the SKID
  // parameter shadows the imported SKID state name inside this module.

  stage_state_e       state_q,     state_d;
  logic [PC_W-1:0]    main_pc_q,   main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    skid_pc_q,   skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

  logic accept;
  logic drain;

  // Outputs come straight from registers; payload is cleared whenever the
  // stage empties, so pc_o/instr_o already read 0/NOP while EMPTY.
  assign valid_o = (state_q != pipe_pkg::EMPTY);
  assign pc_o    = main_pc_q;
  assign instr_o = main_instr_q;
  assign count_o = state_count(state_q);

  generate
    if (SKID) begin : g_skid_ready
      // Registered ready: depends only on state and reset, never on ready_i.
      assign ready_o = ~rst & (state_q != pipe_pkg::SKID);
    end else begin : g_plain_ready
      // Single register: can take a new entry whenever the head leaves or is absent.
      assign ready_o = ~rst & (~valid_o | ready_i);
    end
  endgenerate

  assign accept = valid_i & ready_o;
  assign drain  = valid_o & ready_i;

  // Next-state and payload movement for the occupancy FSM; flush overrides all.
  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    case (state_q)
      pipe_pkg::EMPTY: begin
        if (accept) begin
          state_d      = pipe_pkg::FULL;
          main_pc_d    = pc_i;
          main_instr_d = instr_i;
        end
      end

      pipe_pkg::FULL: begin
        if (accept && drain) begin
          main_pc_d    = pc_i;
          main_instr_d = instr_i;
        end else if (accept) begin
          // Only reachable with SKID=1: in SKID=0 a stalled head keeps ready_o low.
          state_d      = pipe_pkg::SKID;
          skid_pc_d    = pc_i;
          skid_instr_d = instr_i;
        end else if (drain) begin
          state_d      = pipe_pkg::EMPTY;
          main_pc_d    = '0;
          main_instr_d = NOP_INSTR;
        end
      end

      pipe_pkg::SKID: begin
        // ready_o is low here, so the only movement is skid -> main on drain.
        if (drain) begin
          state_d      = pipe_pkg::FULL;
          main_pc_d    = skid_pc_q;
          main_instr_d = skid_instr_q;
          skid_pc_d    = '0;
          skid_instr_d = NOP_INSTR;
        end
      end

      default: begin
        state_d      = pipe_pkg::EMPTY;
        main_pc_d    = '0;
        main_instr_d = NOP_INSTR;
        skid_pc_d    = '0;
        skid_instr_d = NOP_INSTR;
      end
    endcase

    // A drain in this cycle has already been seen by decode; any accept is
    // consumed from fetch and simply not stored.
    if (flush) begin
      state_d      = pipe_pkg::EMPTY;
      main_pc_d    = '0;
      main_instr_d = NOP_INSTR;
      skid_pc_d    = '0;
      skid_instr_d = NOP_INSTR;
    end
  end

  // State and payload registers with synchronous reset to the empty bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= pipe_pkg::EMPTY;
      main_pc_q    <= '0;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule
